// File: rtl/synchronizer_filter.sv
// synchronizer_filter: multi-channel level synchronizer with a per-channel
// stability (glitch) filter and optional registered rise/fall pulses.
// Each channel passes through a SYNC_DEPTH flop chain; the synchronized level
// must then persist for FILT_CYCLES consecutive cycles before out follows it.
// Optional feature macro: SYNC_FILTER_EDGE_PULSE_EN (when undefined, rise and
// fall are constant 0 and no pulse registers exist).
module synchronizer_filter #(
    parameter int                NUM_CH      = 4,
    parameter int                SYNC_DEPTH  = 2,
    parameter int                FILT_CYCLES = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall
);

    localparam int               CNT_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_DEPTH];
    logic [NUM_CH-1:0] ss;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] out_d;

    // Plain flop chain per channel; nothing sits between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_DEPTH; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= in;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign ss = sync_q[SYNC_DEPTH-1];

    // Filter decision: count consecutive disagreement cycles, adopt the new
    // level on the last one, and restart from zero whenever ss agrees again.
    always_comb begin
        out_d = out;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch] = '0;
            if (ss[ch] != out[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    out_d[ch] = ss[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    // Filtered output and disagreement counters; reset discards partial counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= RESET_VAL;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            out <= out_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

`ifdef SYNC_FILTER_EDGE_PULSE_EN
    // Edge pulses register on the same edge as out, so they line up with the
    // first cycle that shows the new level; a single bit cannot both rise and fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= out_d & ~out;
            fall <= ~out_d & out;
        end
    end
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_synchronizer_filter.sv
// tb_synchronizer_filter: table-driven and randomized checks of
// synchronizer_filter against a history-based reference model.
// Pulse expectations follow SYNC_FILTER_EDGE_PULSE_EN.
module tb_synchronizer_filter;

    localparam int         NUM_CH      = 4;
    localparam int         SYNC_DEPTH  = 2;
    localparam int         FILT_CYCLES = 4;
    localparam logic [3:0] RESET_VAL   = 4'b0101;
`ifdef SYNC_FILTER_EDGE_PULSE_EN
    localparam bit PULSES = 1'b1;
`else
    localparam bit PULSES = 1'b0;
`endif

    typedef struct {
        logic [3:0] in_val;
        int         hold;
        logic [3:0] exp_out;
        logic [3:0] exp_rise;
        logic [3:0] exp_fall;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] in_lvl;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] m_pipe [SYNC_DEPTH];
    logic [3:0] m_out;
    logic [3:0] m_rise;
    logic [3:0] m_fall;
    logic [3:0] ss_hist [$];
    int         since [NUM_CH];

    vec_t tbl [14];

    synchronizer_filter #(
        .NUM_CH     (NUM_CH),
        .SYNC_DEPTH (SYNC_DEPTH),
        .FILT_CYCLES(FILT_CYCLES),
        .RESET_VAL  (RESET_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in_lvl),
        .out (out),
        .rise(rise),
        .fall(fall)
    );

    // Free-running destination clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void modelReset();
        for (int k = 0; k < SYNC_DEPTH; k++) m_pipe[k] = RESET_VAL;
        m_out  = RESET_VAL;
        m_rise = '0;
        m_fall = '0;
        ss_hist.delete();
        for (int ch = 0; ch < NUM_CH; ch++) since[ch] = 0;
    endfunction

    // A channel adopts a new level once the last FILT_CYCLES synchronized
    // samples, all taken since its previous change, disagree with it.
    function automatic void modelStep(input logic [3:0] sample);
        logic [3:0] ss_now;
        logic [3:0] next_out;
        bit         differs;
        ss_now = m_pipe[SYNC_DEPTH-1];
        ss_hist.push_back(ss_now);
        if (ss_hist.size() > FILT_CYCLES) void'(ss_hist.pop_front());
        next_out = m_out;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            since[ch]++;
            if (since[ch] >= FILT_CYCLES) begin
                differs = 1'b1;
                foreach (ss_hist[j]) if (ss_hist[j][ch] == m_out[ch]) differs = 1'b0;
                if (differs) begin
                    next_out[ch] = ~m_out[ch];
                    since[ch]    = 0;
                end
            end
        end
        m_rise = PULSES ? (next_out & ~m_out) : 4'b0000;
        m_fall = PULSES ? (~next_out & m_out) : 4'b0000;
        m_out  = next_out;
        for (int k = SYNC_DEPTH - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = sample;
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) modelStep(in_lvl);
        @(negedge clk);
        checkOutput("model out", out, m_out);
        checkOutput("model rise", rise, m_rise);
        checkOutput("model fall", fall, m_fall);
    endtask

    task automatic applyStimulus(input logic [3:0] val, input int cycles);
        in_lvl = val;
        repeat (cycles) tick();
    endtask

    task automatic assertReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("async rst out", out, RESET_VAL);
        checkOutput("async rst rise", rise, 4'b0000);
        checkOutput("async rst fall", fall, 4'b0000);
    endtask

    task automatic checkConst(input string name, input logic [3:0] exp_out,
                              input logic [3:0] exp_rise, input logic [3:0] exp_fall);
        checkOutput({name, " out"}, out, exp_out);
        checkOutput({name, " rise"}, rise, PULSES ? exp_rise : 4'b0000);
        checkOutput({name, " fall"}, fall, PULSES ? exp_fall : 4'b0000);
    endtask

    // Test sequence: reset, vector table, hand-written corner cases, random.
    initial begin
        tbl[0]  = '{4'b0101, 3, 4'b0101, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0111, 5, 4'b0101, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0111, 1, 4'b0111, 4'b0010, 4'b0000};
        tbl[3]  = '{4'b0111, 1, 4'b0111, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b1111, 3, 4'b0111, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0111, 8, 4'b0111, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1111, 3, 4'b0111, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0111, 1, 4'b0111, 4'b0000, 4'b0000};
        tbl[8]  = '{4'b1111, 5, 4'b0111, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b1111, 1, 4'b1111, 4'b1000, 4'b0000};
        tbl[10] = '{4'b1111, 1, 4'b1111, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1010, 5, 4'b1111, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1010, 1, 4'b1010, 4'b0000, 4'b0101};
        tbl[13] = '{4'b1010, 1, 4'b1010, 4'b0000, 4'b0000};

        rst    = 1'b1;
        in_lvl = RESET_VAL;
        #1;
        modelReset();
        checkConst("time0 rst", RESET_VAL, 4'b0000, 4'b0000);
        repeat (3) tick();
        checkConst("held rst", RESET_VAL, 4'b0000, 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].in_val, tbl[i].hold);
            checkConst($sformatf("tbl%0d", i), tbl[i].exp_out, tbl[i].exp_rise, tbl[i].exp_fall);
        end

        // Reset at filter count 2 of an in[1] change, then full latency again.
        assertReset();
        tick();
        rst = 1'b0;
        applyStimulus(4'b0101, 3);
        checkConst("pre midrst", 4'b0101, 4'b0000, 4'b0000);
        applyStimulus(4'b0111, 4);
        assertReset();
        checkConst("midrst", 4'b0101, 4'b0000, 4'b0000);
        repeat (2) tick();
        rst = 1'b0;
        applyStimulus(4'b0111, 5);
        checkConst("midrst edge5", 4'b0101, 4'b0000, 4'b0000);
        applyStimulus(4'b0111, 1);
        checkConst("midrst edge6", 4'b0111, 4'b0010, 4'b0000);

        // Two channels falling on the same edge.
        assertReset();
        tick();
        rst = 1'b0;
        applyStimulus(4'b0000, 5);
        checkConst("dual fall edge5", 4'b0101, 4'b0000, 4'b0000);
        applyStimulus(4'b0000, 1);
        checkConst("dual fall edge6", 4'b0000, 4'b0000, 4'b0101);
        applyStimulus(4'b0000, 1);
        checkConst("dual fall after", 4'b0000, 4'b0000, 4'b0000);

        // Random levels with random hold lengths and occasional resets.
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 19) == 0) begin
                assertReset();
                tick();
                rst = 1'b0;
            end
            applyStimulus(4'($urandom), int'($urandom_range(1, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
